// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = ~PAR_EVEN;

    localparam int unsigned MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and bit-value sampler for uart_rx_param.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around the sample point instead of a single sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_s,
    input  logic                  start,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sample_c,
    output logic                  bit_c
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] half;
    logic                  bit_done;
    logic                  mid_q, mid_d;
`ifdef UART_RX_MAJORITY_EN
    logic                  early_q, early_d;
`endif

    // The bit value is taken at cnt==P>>1 and handed to the FSM one cycle later, so the
    // decision cycle is the same whether or not the late majority sample is used.
    always_comb begin
        half     = presc_q >> 1;
        bit_done = (cnt_q == presc_q - PRESCALE_W'(1));
        sample_c = (cnt_q == half + PRESCALE_W'(1));
        presc_d  = presc_q;
        cnt_d    = bit_done ? '0 : cnt_q + PRESCALE_W'(1);
        mid_d    = (cnt_q == half) ? rx_s : mid_q;
`ifdef UART_RX_MAJORITY_EN
        early_d  = (cnt_q == half - PRESCALE_W'(1)) ? rx_s : early_q;
        bit_c    = (early_q & mid_q) | (early_q & rx_s) | (mid_q & rx_s);
`else
        bit_c    = mid_q;
`endif
        // Detection cycle counts as cnt 0; illegal prescales are clamped so the FSM always advances.
        if (start) begin
            cnt_d   = PRESCALE_W'(1);
            presc_d = (prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : prescale;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            presc_q <= PRESCALE_W'(MIN_PRESCALE);
            mid_q   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            early_q <= 1'b1;
`endif
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            mid_q   <= mid_d;
`ifdef UART_RX_MAJORITY_EN
            early_q <= early_d;
`endif
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, frame FSM, shift register, parity and stop checks.
// Optional build macro UART_RX_MAJORITY_EN enables 3-sample majority voting in uart_rx_sampler.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_enable,
    input  logic                  par_type,
    input  logic                  stop_two,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic              sync1_q, sync1_d;
    logic              rx_s_q, rx_s_d;
    logic              rx_prev_q, rx_prev_d;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_type_q, par_type_d;
    logic              stop_two_q, stop_two_d;
    logic              par_fail_q, par_fail_d;
    logic              stop_fail_q, stop_fail_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              par_err_q, par_err_d;
    logic              stop_err_q, stop_err_d;
    logic              busy_q, busy_d;
    logic              start_c;
    logic              sample_c;
    logic              bit_c;
    logic              stop_bad;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx_s     (rx_s_q),
        .start    (start_c),
        .prescale (prescale),
        .sample_c (sample_c),
        .bit_c    (bit_c)
    );

    always_comb begin
        sync1_d      = data;
        rx_s_d       = sync1_q;
        rx_prev_d    = rx_s_q;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_en_d     = par_en_q;
        par_type_d   = par_type_q;
        stop_two_d   = stop_two_q;
        par_fail_d   = par_fail_q;
        stop_fail_d  = stop_fail_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stop_err_d   = 1'b0;
        start_c      = 1'b0;
        stop_bad     = stop_fail_q | ~bit_c;

        unique case (state_q)
            IDLE: begin
                // Edge, not level: a line stuck low after a bad stop bit cannot restart a frame.
                if (rx_prev_q && !rx_s_q) begin
                    start_c     = 1'b1;
                    state_d     = START;
                    bit_cnt_d   = '0;
                    par_en_d    = par_enable;
                    par_type_d  = par_type;
                    stop_two_d  = stop_two;
                    par_fail_d  = 1'b0;
                    stop_fail_d = 1'b0;
                end
            end
            START: begin
                if (sample_c) begin
                    state_d = bit_c ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_c) begin
                    shift_d = {bit_c, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_c) begin
                    if (bit_c != ((^shift_q) ^ (par_type_q == PAR_ODD))) begin
                        par_fail_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_c) begin
                    stop_fail_d = stop_bad;
                    if (!stop_two_q || bit_cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        if (!(par_fail_q || stop_bad)) begin
                            data_valid_d = 1'b1;
                            data_out_d   = shift_q;
                        end else begin
                            par_err_d  = par_fail_q;
                            stop_err_d = stop_bad;
                        end
                    end else begin
                        bit_cnt_d = CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            stop_two_q   <= 1'b0;
            par_fail_q   <= 1'b0;
            stop_fail_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            par_type_q   <= par_type_d;
            stop_two_q   <= stop_two_d;
            par_fail_q   <= par_fail_d;
            stop_fail_q  <= stop_fail_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stop_err_q   <= stop_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stop_err   = stop_err_q;
    assign busy       = busy_q;

endmodule
